// File: rtl/video_timing_pkg.sv
// Shared raster timing constants (640x480@60 defaults), the stage-1 decode
// record and helpers that place a sync pulse after the active area and porch.
package video_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // Decoded flags captured by stage 1 alongside the raw counts.
  typedef struct packed {
    logic valid;   // stage holds a real pixel (cleared by reset)
    logic h_act;   // inside horizontal active area
    logic v_act;   // inside vertical active area
    logic h_sync;  // inside horizontal sync window
    logic v_sync;  // inside vertical sync window
    logic line0;   // first pixel of a line
    logic frame0;  // first pixel of a frame
    logic oor;     // count beyond the raster totals
  } stage1_flags_t;

  // First count inside the sync window: right after active area and front porch.
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // First count past the sync window.
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction

endpackage

// File: rtl/sync_window.sv
// Half-open window decode: in_window = START <= count < END, unsigned.
// Compared one bit wider so END may equal 2**LEN without wrapping.
module sync_window #(
  parameter int START = 0,
  parameter int END   = 1,
  parameter int LEN   = 1
) (
  input  logic [LEN-1:0] count,
  output logic           in_window
);

  localparam logic [LEN:0] START_W = (LEN+1)'(START);
  localparam logic [LEN:0] END_W   = (LEN+1)'(END);

  logic [LEN:0] count_w;
  assign count_w = {1'b0, count};

  // A window starting at zero needs only the upper bound.
  generate
    if (START == 0) begin : g_from_zero
      assign in_window = (count_w < END_W);
    end else begin : g_range
      assign in_window = (count_w >= START_W) && (count_w < END_W);
    end
  endgenerate

endmodule

// File: rtl/video_sync_gen.sv
// Two-stage raster timing generator downstream of the pixel counter.
// Stage 1 decodes the incoming counts; stage 2 registers sync/de/coordinates
// and the strobe / line-start / frame-start pulses plus a sticky range error.
//
// Flow control: i_inc is a pure advance qualifier, not a valid/ready pair.
// Both stages load only on a clk edge with i_inc=1, everything holds otherwise,
// and there is no back-pressure toward the pixel counter.
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = video_timing_pkg::H_ACTIVE,
  parameter int H_FP      = video_timing_pkg::H_FP,
  parameter int H_SYNC    = video_timing_pkg::H_SYNC,
  parameter int H_BP      = video_timing_pkg::H_BP,
  parameter int V_ACTIVE  = video_timing_pkg::V_ACTIVE,
  parameter int V_FP      = video_timing_pkg::V_FP,
  parameter int V_SYNC    = video_timing_pkg::V_SYNC,
  parameter int V_BP      = video_timing_pkg::V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int HLEN      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VLEN      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_inc,
  input  logic [HLEN-1:0] i_hcount,
  input  logic [VLEN-1:0] i_vcount,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic [HLEN-1:0] o_x,
  output logic [VLEN-1:0] o_y,
  output logic            o_strobe,
  output logic            o_line_start,
  output logic            o_frame_start,
  output logic            o_err
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = sync_start(H_ACTIVE, H_FP);
  localparam int HS_END   = sync_end(H_ACTIVE, H_FP, H_SYNC);
  localparam int VS_START = sync_start(V_ACTIVE, V_FP);
  localparam int VS_END   = sync_end(V_ACTIVE, V_FP, V_SYNC);

  // Window decodes of the incoming counts.
  logic h_act, v_act, h_sync, v_sync, h_in, v_in;

  sync_window #(.START(0), .END(H_ACTIVE), .LEN(HLEN)) u_h_act (
    .count(i_hcount), .in_window(h_act));
  sync_window #(.START(0), .END(V_ACTIVE), .LEN(VLEN)) u_v_act (
    .count(i_vcount), .in_window(v_act));
  sync_window #(.START(HS_START), .END(HS_END), .LEN(HLEN)) u_h_sync (
    .count(i_hcount), .in_window(h_sync));
  sync_window #(.START(VS_START), .END(VS_END), .LEN(VLEN)) u_v_sync (
    .count(i_vcount), .in_window(v_sync));
  sync_window #(.START(0), .END(H_TOTAL), .LEN(HLEN)) u_h_in (
    .count(i_hcount), .in_window(h_in));
  sync_window #(.START(0), .END(V_TOTAL), .LEN(VLEN)) u_v_in (
    .count(i_vcount), .in_window(v_in));

  // Stage 1 state.
  stage1_flags_t   s1_q, s1_d;
  logic [HLEN-1:0] s1_hc_q, s1_hc_d;
  logic [VLEN-1:0] s1_vc_q, s1_vc_d;

  // Stage 2 state (drives the outputs directly).
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            de_q, de_d;
  logic [HLEN-1:0] x_q, x_d;
  logic [VLEN-1:0] y_q, y_d;
  logic            strobe_q, strobe_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic            err_q, err_d;

  // Stage 1 next state: capture decodes and counts on enabled edges.
  always_comb begin
    s1_d    = s1_q;
    s1_hc_d = s1_hc_q;
    s1_vc_d = s1_vc_q;
    if (i_inc) begin
      s1_d.valid  = 1'b1;
      s1_d.h_act  = h_act;
      s1_d.v_act  = v_act;
      s1_d.h_sync = h_sync;
      s1_d.v_sync = v_sync;
      s1_d.line0  = (i_hcount == '0);
      s1_d.frame0 = (i_hcount == '0) && (i_vcount == '0);
      s1_d.oor    = !h_in || !v_in;
      s1_hc_d     = i_hcount;
      s1_vc_d     = i_vcount;
    end
  end

  // Stage 1 registers; reset drops the valid bit so stale data never pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= '0;
      s1_hc_q <= '0;
      s1_vc_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s1_hc_q <= s1_hc_d;
      s1_vc_q <= s1_vc_d;
    end
  end

  // Stage 2 next state: out-of-range pixels are forced to blanking.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    strobe_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    err_d         = err_q;
    if (i_inc) begin
      de_d          = s1_q.h_act && s1_q.v_act && !s1_q.oor;
      x_d           = de_d ? s1_hc_q : '0;
      y_d           = de_d ? s1_vc_q : '0;
      hsync_d       = (s1_q.h_sync && !s1_q.oor) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = (s1_q.v_sync && !s1_q.oor) ? VSYNC_POL : ~VSYNC_POL;
      strobe_d      = s1_q.valid;
      line_start_d  = s1_q.valid && s1_q.line0;
      frame_start_d = s1_q.valid && s1_q.frame0;
      if (s1_q.valid && s1_q.oor) begin
        err_d = 1'b1;
      end
    end
  end

  // Stage 2 registers; syncs reset to their inactive level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      strobe_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      strobe_q      <= strobe_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      err_q         <= err_d;
    end
  end

  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_de          = de_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_strobe      = strobe_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen at the 640x480@60 defaults: directed vectors with
// literal expectations plus a per-cycle comparison against a raster model.
module tb_video_sync_gen;

  localparam int W = 10;

  logic         clk;
  logic         rstn;
  logic         i_inc;
  logic [W-1:0] i_hcount;
  logic [W-1:0] i_vcount;
  logic         o_hsync, o_vsync, o_de, o_strobe, o_line_start, o_frame_start, o_err;
  logic [W-1:0] o_x, o_y;

  int n_vec = 0;
  int n_bad = 0;
  int ls_cnt = 0;
  int fs_cnt = 0;
  bit cnt_on = 0;

  video_sync_gen dut (
    .clk(clk), .rstn(rstn), .i_inc(i_inc),
    .i_hcount(i_hcount), .i_vcount(i_vcount),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .o_x(o_x), .o_y(o_y), .o_strobe(o_strobe),
    .o_line_start(o_line_start), .o_frame_start(o_frame_start), .o_err(o_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raster rules for one pixel, straight from the timing numbers.
  typedef struct packed {
    logic         hs;
    logic         vs;
    logic         de;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ls;
    logic         fs;
    logic         oor;
  } pix_t;

  function automatic pix_t pix_model(input int hc, input int vc);
    pix_t p;
    p.oor = (hc >= 800) || (vc >= 525);
    p.de  = !p.oor && (hc < 640) && (vc < 480);
    p.hs  = (!p.oor && hc >= 656 && hc < 752) ? 1'b0 : 1'b1;
    p.vs  = (!p.oor && vc >= 490 && vc < 492) ? 1'b0 : 1'b1;
    p.x   = p.de ? W'(hc) : '0;
    p.y   = p.de ? W'(vc) : '0;
    p.ls  = (hc == 0);
    p.fs  = (hc == 0) && (vc == 0);
    return p;
  endfunction

  // Model: counts taken on enabled edges since reset; the outputs after an
  // enabled edge show the pixel taken on the previous enabled edge.
  logic [2*W-1:0] exp_q[$];
  logic         exp_hs = 1'b1, exp_vs = 1'b1, exp_de = 1'b0;
  logic [W-1:0] exp_x = '0, exp_y = '0;
  logic         exp_st = 1'b0, exp_ls = 1'b0, exp_fs = 1'b0, exp_err = 1'b0;

  always @(posedge clk or negedge rstn) begin : model
    pix_t p;
    if (!rstn) begin
      exp_q.delete();
      exp_hs = 1'b1; exp_vs = 1'b1; exp_de = 1'b0; exp_x = '0; exp_y = '0;
      exp_st = 1'b0; exp_ls = 1'b0; exp_fs = 1'b0; exp_err = 1'b0;
    end else if (i_inc) begin
      exp_q.push_back({i_hcount, i_vcount});
      if (exp_q.size() > 2) void'(exp_q.pop_front());
      if (exp_q.size() == 2) begin
        p = pix_model(int'(exp_q[0][2*W-1:W]), int'(exp_q[0][W-1:0]));
        exp_hs = p.hs; exp_vs = p.vs; exp_de = p.de; exp_x = p.x; exp_y = p.y;
        exp_st = 1'b1; exp_ls = p.ls; exp_fs = p.fs;
        if (p.oor) exp_err = 1'b1;
      end else begin
        exp_st = 1'b0; exp_ls = 1'b0; exp_fs = 1'b0;
      end
    end else begin
      exp_st = 1'b0; exp_ls = 1'b0; exp_fs = 1'b0;
    end
  end

  // Scoreboard: full output compare against the model, once per cycle.
  task automatic cycle_compare();
    n_vec++;
    if ({o_hsync, o_vsync, o_de, o_x, o_y, o_strobe, o_line_start, o_frame_start, o_err} !==
        {exp_hs, exp_vs, exp_de, exp_x, exp_y, exp_st, exp_ls, exp_fs, exp_err}) begin
      n_bad++;
      $display("FAIL cycle_cmp t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d st=%b ls=%b fs=%b err=%b want hs=%b vs=%b de=%b x=%0d y=%0d st=%b ls=%b fs=%b err=%b",
               $time, o_hsync, o_vsync, o_de, o_x, o_y, o_strobe, o_line_start, o_frame_start, o_err,
               exp_hs, exp_vs, exp_de, exp_x, exp_y, exp_st, exp_ls, exp_fs, exp_err);
    end
    if (cnt_on) begin
      ls_cnt += int'(o_line_start);
      fs_cnt += int'(o_frame_start);
    end
  endtask

  // Literal check against a hand-computed value.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: present inputs for one edge, compare at the falling edge, and
  // return 2ns after the rising edge that sampled them.
  task automatic step(input logic inc, input int hc, input int vc);
    i_inc    = inc;
    i_hcount = W'(hc);
    i_vcount = W'(vc);
    @(negedge clk);
    cycle_compare();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"}, 32'(o_hsync), 1);
    chk({tag, "_vsync"}, 32'(o_vsync), 1);
    chk({tag, "_de"}, 32'(o_de), 0);
    chk({tag, "_x"}, 32'(o_x), 0);
    chk({tag, "_y"}, 32'(o_y), 0);
    chk({tag, "_strobe"}, 32'(o_strobe), 0);
    chk({tag, "_line_start"}, 32'(o_line_start), 0);
    chk({tag, "_frame_start"}, 32'(o_frame_start), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
  endtask

  // Directed table: counts and the outputs each must produce.
  int t_hc[13] = '{639, 640, 655, 656, 751, 752, 0, 0, 100, 100, 700, 5, 10};
  int t_vc[13] = '{0,   0,   0,   0,   0,   0,   0, 5, 489, 490, 491, 492, 479};
  int t_de[13] = '{1,   0,   0,   0,   0,   0,   1, 1, 0,   0,   0,   0,   1};
  int t_x[13]  = '{639, 0,   0,   0,   0,   0,   0, 0, 0,   0,   0,   0,   10};
  int t_y[13]  = '{0,   0,   0,   0,   0,   0,   0, 5, 0,   0,   0,   0,   479};
  int t_hs[13] = '{1,   1,   1,   0,   0,   1,   1, 1, 1,   1,   0,   1,   1};
  int t_vs[13] = '{1,   1,   1,   1,   1,   1,   1, 1, 1,   0,   0,   1,   1};
  int t_ls[13] = '{0,   0,   0,   0,   0,   0,   1, 1, 0,   0,   0,   0,   0};
  int t_fs[13] = '{0,   0,   0,   0,   0,   0,   1, 0, 0,   0,   0,   0,   0};

  task automatic chk_entry(input int i);
    chk($sformatf("tbl%0d_de", i), 32'(o_de), 32'(t_de[i]));
    chk($sformatf("tbl%0d_x", i), 32'(o_x), 32'(t_x[i]));
    chk($sformatf("tbl%0d_y", i), 32'(o_y), 32'(t_y[i]));
    chk($sformatf("tbl%0d_hsync", i), 32'(o_hsync), 32'(t_hs[i]));
    chk($sformatf("tbl%0d_vsync", i), 32'(o_vsync), 32'(t_vs[i]));
    chk($sformatf("tbl%0d_line_start", i), 32'(o_line_start), 32'(t_ls[i]));
    chk($sformatf("tbl%0d_frame_start", i), 32'(o_frame_start), 32'(t_fs[i]));
    chk($sformatf("tbl%0d_strobe", i), 32'(o_strobe), 1);
  endtask

  int sparse_hc[9] = '{0, 1, 639, 640, 655, 656, 751, 752, 799};

  initial begin
    rstn = 1'b0; i_inc = 1'b0; i_hcount = '0; i_vcount = '0;

    // Reset with i_inc idle, then release and idle some more.
    repeat (3) step(0, 0, 0);
    chk_reset_vals("rst_hold");
    rstn = 1'b1;
    repeat (3) step(0, 0, 0);
    chk_reset_vals("rst_idle");

    // Directed table at full rate; first strobe needs two enabled edges.
    step(1, t_hc[0], t_vc[0]);
    chk("first_edge_strobe", 32'(o_strobe), 0);
    for (int i = 1; i < 13; i++) begin
      step(1, t_hc[i], t_vc[i]);
      chk_entry(i - 1);
    end
    step(1, 1, 1);
    chk_entry(12);

    // Counter-style frame: full line 0, sampled pixels on every other line.
    cnt_on = 1'b1;
    ls_cnt = 0;
    fs_cnt = 0;
    for (int h = 0; h < 800; h++) step(1, h, 0);
    for (int v = 1; v < 525; v++) begin
      for (int k = 0; k < 9; k++) step(1, sparse_hc[k], v);
    end
    step(1, 1, 1);
    step(1, 1, 1);
    cnt_on = 1'b0;
    chk("frame_line_starts", 32'(ls_cnt), 525);
    chk("frame_frame_starts", 32'(fs_cnt), 1);

    // 1-of-3 enable duty; junk counts while idle must be ignored.
    for (int h = 636; h < 661; h++) begin
      step(1, h, 2);
      step(0, 800, 600);
      step(0, 900, 900);
    end
    step(1, 100, 3);
    step(0, 0, 0);
    step(1, 101, 3);
    chk("duty_x", 32'(o_x), 100);
    chk("duty_y", 32'(o_y), 3);
    chk("duty_strobe", 32'(o_strobe), 1);
    step(0, 0, 0);
    chk("duty_hold_strobe", 32'(o_strobe), 0);
    chk("duty_hold_x", 32'(o_x), 100);
    chk("duty_hold_de", 32'(o_de), 1);

    // Out-of-range counts: sticky error, forced blanking.
    step(1, 800, 0);
    step(1, 700, 600);
    chk("oor_h_err", 32'(o_err), 1);
    chk("oor_h_de", 32'(o_de), 0);
    chk("oor_h_hsync", 32'(o_hsync), 1);
    step(1, 5, 5);
    chk("oor_v_hsync", 32'(o_hsync), 1);
    chk("oor_v_vsync", 32'(o_vsync), 1);
    chk("oor_v_de", 32'(o_de), 0);
    step(1, 10, 10);
    chk("err_sticky", 32'(o_err), 1);
    chk("err_sticky_de", 32'(o_de), 1);
    chk("err_sticky_x", 32'(o_x), 5);
    step(1, 0, 0);

    // Mid-cycle asynchronous reset with a frame start in flight.
    rstn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    repeat (2) step(1, 0, 0);
    chk_reset_vals("rst_held_inc");
    rstn = 1'b1;
    step(0, 0, 0);
    chk("post_rst_idle_strobe", 32'(o_strobe), 0);
    step(1, 0, 0);
    chk("post_rst_first_strobe", 32'(o_strobe), 0);
    chk("post_rst_first_fs", 32'(o_frame_start), 0);
    step(1, 1, 0);
    chk("post_rst_strobe", 32'(o_strobe), 1);
    chk("post_rst_fs", 32'(o_frame_start), 1);
    chk("post_rst_ls", 32'(o_line_start), 1);
    chk("post_rst_err", 32'(o_err), 0);
    step(1, 2, 0);
    chk("post_rst_fs_single", 32'(o_frame_start), 0);
    step(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
